fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Drains the 8-bit AD sample FIFO, which the polling controller fills with
//  32 samples, 0xCC, 0x0D, 0x0A per frame, and serialises each byte as UART
//  8N1, LSB first, on uart_tx. Sits directly downstream of the polling
//  controller and drives its FIFO read port (rdreq/empty/q).
//  Also reports a byte count and a frame-complete pulse for debug/host sync.
// PARAMETERS
//  CLK_HZ    50_000_000        clk frequency in Hz
//  BAUD      115_200           UART bit rate
//  BAUD_DIV  CLK_HZ/BAUD (434) clk cycles per UART bit; integer division, must be >= 2
//  EOF_BYTE  8'h0A             byte whose completed transmission pulses frame_done
// PORTS
//  clk         in   1   system clock, 50 MHz
//  reset_n     in   1   asynchronous reset, active-low
//  enable      in   1   1 = allowed to start new bytes
//  fifo_empty  in   1   FIFO empty flag
//  fifo_q      in   8   FIFO read data, valid the cycle after fifo_rdreq (normal mode)
//  fifo_rdreq  out  1   FIFO read request; one-cycle pulse per byte
//  uart_tx     out  1   serial output; idle high
//  busy        out  1   1 whenever state != IDLE
//  byte_cnt    out  16  bytes fully transmitted since reset, wraps 0xFFFF->0
//  frame_done  out  1   one-cycle pulse after EOF_BYTE's stop bit completes
//  state_dbg   out  3   current state encoding, for signal tap
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, uart_tx=1, fifo_rdreq=0, busy=0,
//   byte_cnt=0, frame_done=0, baud/bit counters=0, shift reg=0.
//   Reset mid-byte aborts at once: uart_tx returns high, and the popped byte is lost.
//  States and encodings: IDLE=0, REQ=1, LATCH=2, START=3, DATA=4, STOP=5.
//   IDLE : uart_tx=1. If enable && !fifo_empty, go to REQ. Otherwise stay.
//   REQ  : fifo_rdreq=1 for this single cycle only. Go to LATCH.
//   LATCH: shift_reg<=fifo_q; baud_cnt<=0. Go to START.
//   START: uart_tx=0 for BAUD_DIV cycles. Then go to DATA with bit_idx=0.
//   DATA : uart_tx=shift_reg[bit_idx], each bit held BAUD_DIV cycles.
//          After bit 7, go to STOP.
//   STOP : uart_tx=1 for BAUD_DIV cycles. On its last cycle: byte_cnt+=1;
//          frame_done=1 if byte==EOF_BYTE; next=REQ if enable&&!fifo_empty else IDLE.
//  baud_cnt counts 0..BAUD_DIV-1 and clears on every bit boundary.
//  No extra wait states beyond these.
//  Timing: rdreq to the start-bit edge is 2 clk. Back-to-back bytes have a
//   byte period of 10*BAUD_DIV+2 clk, i.e. 2 clk of idle-high gap.
//  fifo_rdreq is never asserted while fifo_empty=1. fifo_empty is sampled
//   only in IDLE and on the last STOP cycle.
//  When enable falls mid-byte, the current byte completes, including its stop
//   bit, and the state then goes to IDLE. enable is ignored in REQ through DATA.
//  fifo_q is captured only in LATCH. Changes to fifo_q at any other time have
//   no effect.
//  uart_tx, fifo_rdreq and frame_done are registered, with no combinational
//   path from inputs.
//  If FIFO goes empty while the last STOP cycle is active, go to IDLE. When
//   data arrives later, IDLE->REQ takes 1 cycle.
//  byte_cnt width is 16 bits and wraps silently, with no saturation.
// TESTING (sim override CLK_HZ=400, BAUD=100 -> BAUD_DIV=4)
//  1 Reset: hold reset_n=0 with fifo non-empty -> uart_tx=1, rdreq=0, busy=0,
//    byte_cnt=0.
//  2 Single byte 0x5A, enable=1 -> one rdreq pulse. Then 2 clk later, line =
//    0 then 0,1,0,1,1,0,1,0 then 1, each for 4 clk. byte_cnt=1, frame_done stays 0.
//  3 Frame 32 x 0x11, then 0xCC, 0x0D, 0x0A queued -> 35 bytes, each period
//    exactly 42 clk. frame_done pulses once, 1 clk, after 0x0A's stop bit.
//    byte_cnt=35.
//  4 Drop enable during DATA bit 3 of 0x81 with 2 bytes queued -> 0x81
//    finishes intact, no further rdreq, busy=0, one byte remains in FIFO.
//  5 Pulse reset_n low during DATA -> uart_tx=1 immediately, state=IDLE. After
//    release with enable=1, the next FIFO byte transmits cleanly.
//  6 Preload byte_cnt near wrap (0xFFFE) with force, then send 3 bytes ->
//    byte_cnt = 0xFFFF, 0x0000, 0x0001. rdreq is never high while fifo_empty=1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit show-ahead-free FIFO and serialises each byte as UART 8N1, LSB first.
// Keeps a wrapping count of sent bytes and pulses frame_done after the end-of-frame byte.
module fifo_uart_tx #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned BAUD     = 115_200,
   parameter int unsigned BAUD_DIV = CLK_HZ / BAUD,
   parameter logic [7:0]  EOF_BYTE = 8'h0A
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_q,
   output logic        fifo_rdreq,
   output logic        uart_tx,
   output logic        busy,
   output logic [15:0] byte_cnt,
   output logic        frame_done,
   output logic [2:0]  state_dbg
);

   localparam int unsigned     CntW     = $clog2(BAUD_DIV);
   localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReq   = 3'd1,
      StLatch = 3'd2,
      StStart = 3'd3,
      StData  = 3'd4,
      StStop  = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [15:0]     byte_cnt_q, byte_cnt_d;
   logic            tx_q, tx_d;
   logic            rdreq_q, rdreq_d;
   logic            frame_done_q, frame_done_d;
   logic            baud_last;

   assign baud_last = (baud_cnt_q == BaudLast);

   always_comb begin
      state_d      = state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_cnt_d   = byte_cnt_q;
      frame_done_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (enable && !fifo_empty) begin
               state_d = StReq;
            end
         end
         StReq: begin
            state_d = StLatch;
         end
         StLatch: begin
            shift_d    = fifo_q;
            baud_cnt_d = '0;
            state_d    = StStart;
         end
         StStart: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_idx_d  = 3'd0;
               state_d    = StData;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         StData: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_last) begin
               baud_cnt_d   = '0;
               byte_cnt_d   = byte_cnt_q + 16'd1;
               frame_done_d = (shift_q == EOF_BYTE);
               // Going straight to REQ keeps back-to-back bytes at a 2-cycle gap.
               state_d      = (enable && !fifo_empty) ? StReq : StIdle;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_comb begin
      rdreq_d = (state_d == StReq);
      tx_d    = 1'b1;
      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         baud_cnt_q   <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         byte_cnt_q   <= 16'h0000;
         tx_q         <= 1'b1;
         rdreq_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_cnt_q   <= byte_cnt_d;
         tx_q         <= tx_d;
         rdreq_q      <= rdreq_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign fifo_rdreq = rdreq_q;
   assign uart_tx    = tx_q;
   assign busy       = (state_q != StIdle);
   assign byte_cnt   = byte_cnt_q;
   assign frame_done = frame_done_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a FIFO model feeds the DUT and a line decoder
// checks every bit sample, latency, byte count and frame_done against the byte order.
module tb_fifo_uart_tx;

   localparam int unsigned Div        = 4;
   localparam int unsigned BytePeriod = 10 * Div + 2;
   localparam logic [7:0]  EofByte    = 8'h0A;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        fifo_empty;
   logic [7:0]  fifo_q = 8'h00;
   logic        fifo_rdreq;
   logic        uart_tx;
   logic        busy;
   logic [15:0] byte_cnt;
   logic        frame_done;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   fifo_uart_tx #(
      .CLK_HZ   (400),
      .BAUD     (100),
      .EOF_BYTE (EofByte)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_q     (fifo_q),
      .fifo_rdreq (fifo_rdreq),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .byte_cnt   (byte_cnt),
      .frame_done (frame_done),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // FIFO model: normal-mode read, data appears the cycle after rdreq.
   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
         fifo_q <= mem[rd_ptr[7:0]];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // Line decoder / reference model state.
   int          cyc = 0;
   int          rdreq_cyc = -100;
   int          rx_pos = 0;
   int          tx_idx = 0;
   int          done_cnt = 0;
   int          fd_count = 0;
   int          last_start = 0;
   bit          rx_active = 1'b0;
   bit          have_last = 1'b0;
   bit          fd_exp = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic [15:0] cnt_offset = 16'h0000;
   bit          chk_period = 1'b0;

   initial begin
      logic exp_bit;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            check_eq("rst_tx", uart_tx, 1'b1);
            check_eq("rst_rdreq", fifo_rdreq, 1'b0);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_cnt", byte_cnt, 16'h0000);
            check_eq("rst_fd", frame_done, 1'b0);
            rx_active = 1'b0;
            done_cnt  = 0;
            fd_exp    = 1'b0;
            have_last = 1'b0;
            tx_idx    = rd_ptr;
         end else begin
            check_eq("frame_done", frame_done, fd_exp);
            if (frame_done) fd_count++;
            fd_exp = 1'b0;
            check_eq("byte_cnt", byte_cnt, 16'(cnt_offset + done_cnt[15:0]));
            if (fifo_rdreq) begin
               check_eq("rdreq_while_empty", fifo_empty, 1'b0);
               rdreq_cyc = cyc;
            end
            if (!chk_period) have_last = 1'b0;
            if (!rx_active && (uart_tx == 1'b0)) begin
               check_eq("start_latency", cyc - rdreq_cyc, 2);
               check_eq("start_popped", (tx_idx < rd_ptr), 1'b1);
               rx_byte = mem[tx_idx[7:0]];
               tx_idx++;
               rx_active = 1'b1;
               rx_pos    = 0;
               if (chk_period && have_last) check_eq("byte_period", cyc - last_start, BytePeriod);
               last_start = cyc;
               have_last  = chk_period;
            end
            if (rx_active) begin
               if (rx_pos < int'(Div))            exp_bit = 1'b0;
               else if (rx_pos < int'(9 * Div))   exp_bit = rx_byte[(rx_pos / Div) - 1];
               else                               exp_bit = 1'b1;
               check_eq("line_bit", uart_tx, exp_bit);
               check_eq("busy_tx", busy, 1'b1);
               rx_pos++;
               if (rx_pos == int'(10 * Div)) begin
                  rx_active = 1'b0;
                  done_cnt++;
                  fd_exp = (rx_byte == EofByte);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
   endtask

   task automatic wait_drained(input string tag, input int budget);
      int n = 0;
      bit ok;
      ok = 1'b0;
      while (n < budget) begin
         if ((wr_ptr == rd_ptr) && !busy && !rx_active) begin
            ok = 1'b1;
            break;
         end
         tick(1);
         n++;
      end
      check_eq(tag, ok, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int r0;
      int f0;
      bit seen;

      // Reset held with a byte waiting, then a single 0x5A.
      reset_n = 1'b0;
      enable  = 1'b1;
      push_byte(8'h5A);
      tick(5);
      check_eq("rst_state", state_dbg, 3'd0);
      reset_n = 1'b1;
      wait_drained("t2_drain", 200);
      tick(2);
      check_eq("t2_rdreq_count", rd_ptr, 1);
      check_eq("t2_byte_cnt", byte_cnt, 16'd1);
      check_eq("t2_fd_count", fd_count, 0);

      // Full frame, back to back.
      chk_period = 1'b1;
      d0 = done_cnt;
      f0 = fd_count;
      for (int i = 0; i < 32; i++) push_byte(8'h11);
      push_byte(8'hCC);
      push_byte(8'h0D);
      push_byte(8'h0A);
      wait_drained("t3_drain", 35 * BytePeriod + 100);
      tick(2);
      chk_period = 1'b0;
      check_eq("t3_fd_pulses", fd_count - f0, 1);
      check_eq("t3_bytes", done_cnt - d0, 35);
      check_eq("t3_byte_cnt", byte_cnt, 16'd36);

      // Enable dropped during DATA bit 3.
      d0 = done_cnt;
      r0 = rd_ptr;
      push_byte(8'h81);
      push_byte(8'h22);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (fifo_rdreq) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
      check_eq("t4_rdreq_seen", seen, 1'b1);
      tick(20);
      enable = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (!busy && !rx_active) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
      check_eq("t4_idle_reached", seen, 1'b1);
      tick(50);
      check_eq("t4_busy", busy, 1'b0);
      check_eq("t4_one_pop", rd_ptr - r0, 1);
      check_eq("t4_left_in_fifo", wr_ptr - rd_ptr, 1);
      check_eq("t4_bytes", done_cnt - d0, 1);

      // Reset in the middle of DATA, then a clean byte.
      enable = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (rx_active && (rx_pos >= 10)) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
      check_eq("t5_in_data", seen, 1'b1);
      reset_n = 1'b0;
      #1;
      check_eq("t5_tx_async", uart_tx, 1'b1);
      check_eq("t5_state_async", state_dbg, 3'd0);
      check_eq("t5_busy_async", busy, 1'b0);
      tick(3);
      reset_n = 1'b1;
      r0 = rd_ptr;
      push_byte(8'h3C);
      wait_drained("t5_drain", 200);
      tick(2);
      check_eq("t5_one_pop", rd_ptr - r0, 1);
      check_eq("t5_bytes", done_cnt, 1);
      check_eq("t5_byte_cnt", byte_cnt, 16'd1);

      // Random bytes with random gaps, exercising empty-at-STOP and re-arm from IDLE.
      for (int i = 0; i < 16; i++) begin
         push_byte(8'($urandom_range(0, 255)));
         tick($urandom_range(0, 60));
      end
      wait_drained("rand_drain", 2000);
      tick(2);

      // Counter wrap.
      force dut.byte_cnt_q = 16'hFFFE;
      cnt_offset = 16'hFFFE - done_cnt[15:0];
      tick(1);
      release dut.byte_cnt_q;
      tick(2);
      check_eq("t6_preload", byte_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
      wait_drained("t6_drain", 400);
      tick(2);
      check_eq("t6_wrapped", byte_cnt, 16'h0001);

      tick(10);
      check_eq("end_fifo_empty", wr_ptr - rd_ptr, 0);
      check_eq("end_all_sent", tx_idx, rd_ptr);
      check_eq("end_rx_idle", rx_active, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
